trans_feeder: RTL and testbench

Transmit-side source for the 128-bit transaction word interface (data/valid/ack). It assembles transaction words from an upstream byte stream and buffers them in a small FIFO. It presents each word to the transaction validator, holding valid until the validator returns its one-cycle ack pulse. It also enforces a minimum one-cycle valid-low gap between words so no word is accepted twice.

---
 rtl/trans_feeder_if.sv | 28 ++
 rtl/trans_feeder.sv | 163 ++++++++++++++++
 tb/tb_trans_feeder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trans_feeder_if.sv
// Byte-stream input and 128-bit transaction word output of trans_feeder.
// master: the feeder side; slave: the upstream source plus the validator.
interface trans_feeder_if;
  logic [7:0]   byte_i;
  logic         byte_valid_i;
  logic         byte_ready_o;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ack_i;

  modport master (
    input  byte_i,
    input  byte_valid_i,
    input  ack_i,
    output byte_ready_o,
    output data_o,
    output valid_o
  );

  modport slave (
    output byte_i,
    output byte_valid_i,
    output ack_i,
    input  byte_ready_o,
    input  data_o,
    input  valid_o
  );
endinterface

// File: rtl/trans_feeder.sv
// Transaction word source: byte assembly, word FIFO, present/ack/gap FSM.
// Optional ack timeout enabled by defining TRANS_FEEDER_TIMEOUT_EN.
module trans_feeder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  trans_feeder_if.master              bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [15:0]                 sent_count_o,
  output logic                        spurious_ack_o,
  output logic                        timeout_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_GAP
  } state_t;

  generate
    if (FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("trans_feeder: bad FIFO_DEPTH or TIMEOUT_CYCLES");
    end
  endgenerate

  state_t         r_state;
  logic [3:0]     r_byte_cnt;
  logic [119:0]   r_asm;
  logic [127:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_level;
  logic [127:0]   r_data;
  logic           r_valid;
  logic [15:0]    r_sent;
  logic           r_spur;

  logic           w_ready;
  logic           w_take;
  logic           w_push;
  logic           w_pop;
  logic           w_ack;
  logic [127:0]   w_word;

  assign w_ready = (r_level != LVL_FULL);
  assign w_take  = bus.byte_valid_i && w_ready;
  assign w_push  = w_take && (r_byte_cnt == 4'd15);
  assign w_word  = {r_asm, bus.byte_i};
  assign w_pop   = (r_state != S_PRESENT) && (r_level != '0);
  assign w_ack   = bus.ack_i;

  assign bus.byte_ready_o = w_ready;
  assign bus.data_o       = r_data;
  assign bus.valid_o      = r_valid;
  assign fifo_level_o     = r_level;
  assign sent_count_o     = r_sent;
  assign spurious_ack_o   = r_spur;

  // First byte shifts to the top, so byte k ends at [127-8k -: 8].
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
    end else if (w_take) begin
      r_byte_cnt <= r_byte_cnt + 4'd1;
      r_asm      <= {r_asm[111:0], bus.byte_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case (1'b1)
        (w_push && !w_pop): r_level <= r_level + (AW+1)'(1);
        (w_pop && !w_push): r_level <= r_level - (AW+1)'(1);
        default:            r_level <= r_level;
      endcase
    end
  end

`ifdef TRANS_FEEDER_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wait;
  logic        r_tmo;
  assign timeout_o = r_tmo;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sent  <= '0;
      r_spur  <= 1'b0;
`ifdef TRANS_FEEDER_TIMEOUT_EN
      r_wait  <= '0;
      r_tmo   <= 1'b0;
`endif
    end else begin
      r_spur <= w_ack && (r_state != S_PRESENT);
`ifdef TRANS_FEEDER_TIMEOUT_EN
      r_tmo  <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE, S_GAP: begin
          if (w_pop) begin
            r_data  <= r_mem[r_rptr];
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
`ifdef TRANS_FEEDER_TIMEOUT_EN
            r_wait  <= '0;
`endif
          end else begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_PRESENT: begin
          if (w_ack) begin
            r_valid <= 1'b0;
            r_sent  <= r_sent + 16'd1;
            r_state <= S_GAP;
          end
`ifdef TRANS_FEEDER_TIMEOUT_EN
          // Ack on the final wait cycle takes priority over the drop.
          else if (r_wait == WAIT_LAST) begin
            r_valid <= 1'b0;
            r_tmo   <= 1'b1;
            r_state <= S_GAP;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
`endif
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trans_feeder.sv
// Self-checking bench for trans_feeder: directed table, hand sequences,
// and random traffic against a queue-based reference model.
module tb_trans_feeder;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  lvl;
  logic [15:0] sent;
  logic        spur;
  logic        tmo;

  trans_feeder_if bus();

  trans_feeder #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .fifo_level_o(lvl),
    .sent_count_o(sent),
    .spurious_ack_o(spur),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: partial-word bytes, queued words, presented word.
  logic [7:0]   m_part[$];
  logic [127:0] m_fifo[$];
  logic [127:0] m_cur;
  bit           m_valid;
  logic [15:0]  m_sent;
  bit           m_spur;
  bit           m_tmo;
  int           m_wait;

  typedef struct {
    logic [7:0]   base;
    logic [7:0]   stp;
    int           ack_dly;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] word_of(input int w);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = 8'(16*w + k);
    return r;
  endfunction

  task automatic model_edge(input bit r, input bit bv,
                            input logic [7:0] b, input bit ack);
    bit           ready;
    bit           can_pop;
    logic [127:0] w;
    if (r) begin
      m_part.delete();
      m_fifo.delete();
      m_cur   = '0;
      m_valid = 0;
      m_sent  = '0;
      m_spur  = 0;
      m_tmo   = 0;
      m_wait  = 0;
      return;
    end
    ready   = (m_fifo.size() != DEPTH);
    can_pop = (m_fifo.size() > 0);
    m_spur  = ack && !m_valid;
    m_tmo   = 0;
    if (m_valid) begin
      if (ack) begin
        m_valid = 0;
        m_sent  = m_sent + 16'd1;
      end
`ifdef TRANS_FEEDER_TIMEOUT_EN
      else if (m_wait == TMO - 1) begin
        m_valid = 0;
        m_tmo   = 1;
      end else begin
        m_wait++;
      end
`endif
    end else if (can_pop) begin
      m_cur   = m_fifo.pop_front();
      m_valid = 1;
      m_wait  = 0;
    end
    if (bv && ready) begin
      m_part.push_back(b);
      if (m_part.size() == 16) begin
        w = '0;
        for (int k = 0; k < 16; k++) w[127-8*k -: 8] = m_part[k];
        m_fifo.push_back(w);
        m_part.delete();
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid", bus.valid_o, m_valid);
    if (m_valid) chk("data", bus.data_o, m_cur);
    chk("ready", bus.byte_ready_o, m_fifo.size() != DEPTH);
    chk("level", lvl, m_fifo.size());
    chk("sent", sent, m_sent);
    chk("spurious", spur, m_spur);
    chk("timeout", tmo, m_tmo);
  endtask

  task automatic step(input bit r, input bit bv,
                      input logic [7:0] b, input bit ack);
    rst              = r;
    bus.byte_valid_i = bv;
    bus.byte_i       = b;
    bus.ack_i        = ack;
    @(posedge clk);
    model_edge(r, bv, b, ack);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0);
  endtask

  task automatic feed_word(input logic [7:0] base, input logic [7:0] stp);
    for (int k = 0; k < 16; k++) step(0, 1, 8'(base + 8'(k) * stp), 0);
  endtask

  initial begin
    int idx;
    int hi;
    int pulses;
    bit rdy;
    bit a;
    bit r;
    bit bv;

    vecs[0] = '{8'h00, 8'h01, 5, 128'h000102030405060708090A0B0C0D0E0F};
    vecs[1] = '{8'hA0, 8'h01, 1, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF};
    vecs[2] = '{8'hFF, 8'hFF, 3, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0};
    vecs[3] = '{8'h10, 8'h11, 0, 128'h102132435465768798A9BACBDCEDFE0F};

    rst              = 1'b1;
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'h00;
    bus.ack_i        = 1'b0;

    // Reset with ack high: ack must be ignored.
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 0);
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_data", bus.data_o, 128'h0);
    chk("rst_sent", sent, 16'd0);
    chk("rst_level", lvl, 3'd0);
    chk("rst_spur", spur, 1'b0);
    chk("rst_tmo", tmo, 1'b0);
    chk("rst_ready", bus.byte_ready_o, 1'b1);

    // Table: assemble, latency, ack timing, count.
    for (int i = 0; i < 4; i++) begin
      feed_word(vecs[i].base, vecs[i].stp);
      chk("tbl_valid_early", bus.valid_o, 1'b0);
      idle();
      chk("tbl_valid", bus.valid_o, 1'b1);
      chk("tbl_data", bus.data_o, vecs[i].exp);
      repeat (vecs[i].ack_dly) idle();
      chk("tbl_hold", bus.data_o, vecs[i].exp);
      step(0, 0, 8'h00, 1);
      chk("tbl_ack_drop", bus.valid_o, 1'b0);
      chk("tbl_sent", sent, 16'(i + 1));
      idle();
      idle();
    end

    // Spurious ack in IDLE.
    step(0, 0, 8'h00, 1);
    chk("spur_pulse", spur, 1'b1);
    chk("spur_sent", sent, 16'd4);
    chk("spur_valid", bus.valid_o, 1'b0);
    idle();
    chk("spur_clear", spur, 1'b0);

    // Reset mid-word discards the partial bytes.
    for (int k = 0; k < 7; k++) step(0, 1, 8'(8'h55 + k), 0);
    step(1, 0, 8'h00, 0);
    feed_word(8'hA0, 8'h01);
    idle();
    chk("midw_valid", bus.valid_o, 1'b1);
    chk("midw_data", bus.data_o, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);

    // Reset mid-PRESENT drops the presented word.
    step(1, 0, 8'h00, 0);
    chk("midp_valid", bus.valid_o, 1'b0);
    chk("midp_sent", sent, 16'd0);
    idle();
    chk("midp_stay", bus.valid_o, 1'b0);

`ifndef TRANS_FEEDER_TIMEOUT_EN
    // Fill the FIFO with no ack, then drain with back-to-back acks.
    step(1, 0, 8'h00, 0);
    idx = 0;
    for (int c = 0; c < 200 && idx < 80; c++) begin
      rdy = (m_fifo.size() != DEPTH);
      step(0, 1, 8'(idx), 0);
      if (rdy) idx++;
    end
    chk("full_level", lvl, 3'd4);
    chk("full_ready", bus.byte_ready_o, 1'b0);
    chk("full_data", bus.data_o, word_of(0));
    repeat (5) step(0, 1, 8'(idx), 0);
    chk("full_hold_level", lvl, 3'd4);
    chk("full_hold_ready", bus.byte_ready_o, 1'b0);
    step(0, 1, 8'(idx), 1);
    chk("gap_valid", bus.valid_o, 1'b0);
    chk("gap_sent", sent, 16'd1);
    step(0, 1, 8'(idx), 0);
    chk("gap_next_valid", bus.valid_o, 1'b1);
    chk("gap_next_data", bus.data_o, word_of(1));
    for (int c = 0; c < 400 && m_sent != 16'd6; c++) begin
      rdy = (m_fifo.size() != DEPTH);
      a   = m_valid;
      step(0, idx < 96, 8'(idx), a);
      if (rdy && idx < 96) idx++;
    end
    chk("drain_sent", sent, 16'd6);
    chk("drain_level", lvl, 3'd0);
    chk("drain_bytes", idx, 96);
`else
    // Timeout: valid held for TMO cycles, one pulse, next word follows.
    step(1, 0, 8'h00, 0);
    feed_word(8'h30, 8'h01);
    idle();
    hi     = 0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.valid_o) hi++;
      if (tmo) pulses++;
      idle();
    end
    chk("tmo_hi_cycles", hi, TMO);
    chk("tmo_pulses", pulses, 1);
    chk("tmo_sent", sent, 16'd0);
    feed_word(8'h40, 8'h01);
    idle();
    chk("tmo_next_valid", bus.valid_o, 1'b1);
    chk("tmo_next_data", bus.data_o, 128'h404142434445464748494A4B4C4D4E4F);
`endif

    // Random traffic against the model.
    step(1, 0, 8'h00, 0);
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 399) == 0);
      bv = ($urandom_range(0, 3) != 0);
      if (m_valid)
        a = ((c / 300) % 2 == 0) ? ($urandom_range(0, 2) == 0)
                                 : ($urandom_range(0, 30) == 0);
      else
        a = ($urandom_range(0, 15) == 0);
      step(r, bv, 8'($urandom), a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
